i2c_wb_seq_ctrl: RTL and testbench

Parametrised command sequencer that drives the Wishbone host side of the I2C master core.
- Registers: PRER_LO=0, PRER_HI=1, CTR=2, TXR/RXR=3, CR/SR=4.
- Executes single-byte register writes and reads on a paged slave. Sends a page-select sub-transaction only when the page changes.
- Wishbone handshake is ack-driven, not fixed-delay.
- Adds repeated-start reads, NACK retry, arbitration-loss detect and an optional poll watchdog.

---
 rtl/i2c_wb_pkg.sv | 49 ++++
 rtl/i2c_wb_access.sv | 63 ++++++
 rtl/i2c_wb_seq_ctrl.sv | 259 +++++++++++++++++++++++++
 tb/tb_i2c_wb_seq_ctrl.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_wb_pkg.sv
// Shared constants and types for the Wishbone I2C command sequencer:
// core register map, CR command bytes, SR bit positions, FSM/phase/error encodings.
package i2c_wb_pkg;

   localparam logic [2:0] ADR_PRER_LO = 3'd0;
   localparam logic [2:0] ADR_PRER_HI = 3'd1;
   localparam logic [2:0] ADR_CTR     = 3'd2;
   localparam logic [2:0] ADR_TXR     = 3'd3;
   localparam logic [2:0] ADR_RXR     = 3'd3;
   localparam logic [2:0] ADR_CR      = 3'd4;
   localparam logic [2:0] ADR_SR      = 3'd4;

   localparam logic [7:0] CMD_STA_WR      = 8'h90;
   localparam logic [7:0] CMD_WR          = 8'h10;
   localparam logic [7:0] CMD_WR_STO      = 8'h50;
   localparam logic [7:0] CMD_RD_NACK_STO = 8'h68;
   localparam logic [7:0] CMD_STO         = 8'h40;
   localparam logic [7:0] CTR_CORE_EN     = 8'h80;

   localparam int SR_TIP   = 1;
   localparam int SR_AL    = 5;
   localparam int SR_RXACK = 7;

   typedef enum logic [3:0] {
      ST_INIT_LO, ST_INIT_HI, ST_INIT_CTR, ST_IDLE, ST_TX_WR, ST_CR_WR,
      ST_POLL, ST_RX_RD, ST_STOP_WR, ST_STOP_POLL, ST_FIN
   } state_e;

   typedef enum logic [1:0] {PH_PG, PH_XFER_W, PH_XFER_R} phase_e;

   typedef enum logic [1:0] {
      ERR_OK = 2'b00, ERR_NACK = 2'b01, ERR_TIMEOUT = 2'b10, ERR_ARB = 2'b11
   } err_e;

   // Byte 2 of a read is the repeated start; byte 3 exists only for reads.
   function automatic logic [7:0] cr_cmd(input phase_e ph, input logic [1:0] step);
      case (step)
         2'd0:    return CMD_STA_WR;
         2'd1:    return CMD_WR;
         2'd2:    return (ph == PH_XFER_R) ? CMD_STA_WR : CMD_WR_STO;
         default: return CMD_RD_NACK_STO;
      endcase
   endfunction

   function automatic logic [1:0] last_step(input phase_e ph);
      return (ph == PH_XFER_R) ? 2'd3 : 2'd2;
   endfunction

endpackage

// File: rtl/i2c_wb_access.sv
// Single Wishbone access engine: one read or write per request, ack-terminated,
// with at least one idle cycle between strobes.
module i2c_wb_access (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       req_i,
   input  logic       we_i,
   input  logic [2:0] adr_i,
   input  logic [7:0] dat_i,
   output logic       busy_o,
   output logic       ack_pulse_o,
   output logic [7:0] rdat_o,
   output logic [2:0] wb_adr_o,
   output logic [7:0] wb_dat_o,
   input  logic [7:0] wb_dat_i,
   output logic       wb_we_o,
   output logic       wb_stb_o,
   output logic       wb_cyc_o,
   input  logic       wb_ack_i
);

   logic       cyc_q, we_q, ack_q;
   logic [2:0] adr_q;
   logic [7:0] dat_q, rdat_q;

   // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cyc_q  <= 1'b0;
         we_q   <= 1'b0;
         ack_q  <= 1'b0;
         adr_q  <= '0;
         dat_q  <= '0;
         rdat_q <= '0;
      end else begin
         ack_q <= 1'b0;
         if (cyc_q) begin
            if (wb_ack_i) begin
               cyc_q <= 1'b0;
               we_q  <= 1'b0;
               ack_q <= 1'b1;
               if (!we_q) rdat_q <= wb_dat_i;
            end
         end else if (req_i && !ack_q) begin
            // ack_q blocks acceptance, guaranteeing an idle cycle between strobes
            cyc_q <= 1'b1;
            we_q  <= we_i;
            adr_q <= adr_i;
            dat_q <= dat_i;
         end
      end
   end

   assign busy_o      = cyc_q | ack_q;
   assign ack_pulse_o = ack_q;
   assign rdat_o      = rdat_q;
   assign wb_adr_o    = adr_q;
   assign wb_dat_o    = dat_q;
   assign wb_we_o     = we_q;
   assign wb_stb_o    = cyc_q;
   assign wb_cyc_o    = cyc_q;

endmodule

// File: rtl/i2c_wb_seq_ctrl.sv
// Paged-slave register read/write sequencer driving the Wishbone I2C master core.
// Define I2C_SEQ_TIMEOUT_EN to enable the SR poll watchdog (err_code 10).
module i2c_wb_seq_ctrl
   import i2c_wb_pkg::*;
#(
   parameter logic [6:0]  SADR        = 7'h10,
   parameter logic [15:0] PRESCALE    = 16'h003F,
   parameter logic [7:0]  PAGE_REG    = 8'h01,
   parameter int unsigned MAX_RETRY   = 3,
   parameter int unsigned TIMEOUT_CYC = 4096
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        start,
   input  logic        rw,
   input  logic [15:0] address,
   input  logic [7:0]  wdata,
   output logic [7:0]  rdata,
   output logic        rdata_valid,
   output logic        ready,
   output logic        done,
   output logic        error,
   output logic [1:0]  err_code,
   output logic [2:0]  wb_adr_o,
   output logic [7:0]  wb_dat_o,
   input  logic [7:0]  wb_dat_i,
   output logic        wb_we_o,
   output logic        wb_stb_o,
   output logic        wb_cyc_o,
   input  logic        wb_ack_i
);

   localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
   localparam int TW = $clog2(TIMEOUT_CYC + 1);
`ifdef I2C_SEQ_TIMEOUT_EN
   localparam logic TMO_EN = 1'b1;
`else
   localparam logic TMO_EN = 1'b0;
`endif

   state_e        state_q, state_d;
   phase_e        phase_q, phase_d;
   err_e          err_q, err_d;
   logic [1:0]    step_q, step_d;
   logic [RW-1:0] retry_q, retry_d;
   logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
   logic          rw_q, rw_d, page_valid_q, page_valid_d, pend_q, pend_d;
   logic [7:0]    page_q, page_d, reg_q, reg_d, wdata_q, wdata_d;
   logic [7:0]    last_page_q, last_page_d, rdata_q, rdata_d;
   logic          rdata_valid_q, rdata_valid_d, done_q, done_d, error_q, error_d;

   logic          acc_need, acc_we, acc_req, acc_busy, acc_ack, in_poll, tmo_hit;
   logic [2:0]    acc_adr;
   logic [7:0]    acc_dat, acc_rdat, tx_byte;

   assign in_poll = (state_q == ST_POLL) || (state_q == ST_STOP_POLL);
   assign tmo_hit = TMO_EN && in_poll && (tmo_cnt_q >= TW'(TIMEOUT_CYC));
   assign acc_req = acc_need && !pend_q && !tmo_hit;

   always_comb begin
      case (step_q)
         2'd0:    tx_byte = {SADR, 1'b0};
         2'd1:    tx_byte = (phase_q == PH_PG) ? PAGE_REG : reg_q;
         default: tx_byte = (phase_q == PH_PG)     ? page_q  :
                            (phase_q == PH_XFER_W) ? wdata_q : {SADR, 1'b1};
      endcase
   end

   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      acc_need = 1'b1;
      acc_we   = 1'b1;
      acc_adr  = ADR_TXR;
      acc_dat  = 8'h00;
      case (state_q)
         ST_INIT_LO:   begin acc_adr = ADR_PRER_LO; acc_dat = PRESCALE[7:0];  end
         ST_INIT_HI:   begin acc_adr = ADR_PRER_HI; acc_dat = PRESCALE[15:8]; end
         ST_INIT_CTR:  begin acc_adr = ADR_CTR;     acc_dat = CTR_CORE_EN;    end
         ST_TX_WR:     acc_dat = tx_byte;
         ST_CR_WR:     begin acc_adr = ADR_CR; acc_dat = cr_cmd(phase_q, step_q); end
         ST_STOP_WR:   begin acc_adr = ADR_CR; acc_dat = CMD_STO; end
         ST_POLL, ST_STOP_POLL: begin acc_we = 1'b0; acc_adr = ADR_SR; end
         ST_RX_RD:     begin acc_we = 1'b0; acc_adr = ADR_RXR; end
         default:      acc_need = 1'b0;
      endcase
   end

   always_comb begin
      state_d       = state_q;
      phase_d       = phase_q;
      err_d         = err_q;
      step_d        = step_q;
      retry_d       = retry_q;
      rw_d          = rw_q;
      page_valid_d  = page_valid_q;
      page_d        = page_q;
      reg_d         = reg_q;
      wdata_d       = wdata_q;
      last_page_d   = last_page_q;
      rdata_d       = rdata_q;
      error_d       = error_q;
      rdata_valid_d = 1'b0;
      done_d        = 1'b0;
      pend_d        = pend_q ? !acc_ack : (acc_req && !acc_busy);

      case (state_q)
         ST_INIT_LO:  if (acc_ack) state_d = ST_INIT_HI;
         ST_INIT_HI:  if (acc_ack) state_d = ST_INIT_CTR;
         ST_INIT_CTR: if (acc_ack) state_d = ST_IDLE;
         ST_IDLE: if (start) begin
            rw_d    = rw;
            page_d  = address[15:8];
            reg_d   = address[7:0];
            wdata_d = wdata;
            error_d = 1'b0;
            err_d   = ERR_OK;
            retry_d = '0;
            step_d  = 2'd0;
            if (!page_valid_q || address[15:8] != last_page_q) phase_d = PH_PG;
            else phase_d = rw ? PH_XFER_R : PH_XFER_W;
            state_d = ST_TX_WR;
         end
         ST_TX_WR:   if (acc_ack) state_d = ST_CR_WR;
         ST_CR_WR:   if (acc_ack) state_d = ST_POLL;
         ST_STOP_WR: if (acc_ack) state_d = ST_STOP_POLL;
         ST_POLL: begin
            if (tmo_hit && !pend_q) begin
               err_d = ERR_TIMEOUT;
               state_d = ST_FIN;
            end else if (acc_ack) begin
               if (acc_rdat[SR_AL]) begin
                  err_d = ERR_ARB;
                  state_d = ST_FIN;
               end else if (acc_rdat[SR_TIP]) begin
                  state_d = ST_POLL;
               end else if (step_q != 2'd3 && acc_rdat[SR_RXACK]) begin
                  state_d = ST_STOP_WR;
               end else if (step_q == last_step(phase_q)) begin
                  case (phase_q)
                     PH_PG: begin
                        last_page_d  = page_q;
                        page_valid_d = 1'b1;
                        phase_d      = rw_q ? PH_XFER_R : PH_XFER_W;
                        step_d       = 2'd0;
                        state_d      = ST_TX_WR;
                     end
                     PH_XFER_W: state_d = ST_FIN;
                     default:   state_d = ST_RX_RD;
                  endcase
               end else begin
                  step_d  = step_q + 2'd1;
                  state_d = (phase_q == PH_XFER_R && step_q == 2'd2) ? ST_CR_WR : ST_TX_WR;
               end
            end
         end
         ST_STOP_POLL: begin
            if (tmo_hit && !pend_q) begin
               err_d = ERR_TIMEOUT;
               state_d = ST_FIN;
            end else if (acc_ack && !acc_rdat[SR_TIP]) begin
               if (retry_q < RW'(MAX_RETRY)) begin
                  retry_d = retry_q + 1'b1;
                  step_d  = 2'd0;
                  state_d = ST_TX_WR;
               end else begin
                  err_d = ERR_NACK;
                  state_d = ST_FIN;
               end
            end
         end
         ST_RX_RD: if (acc_ack) begin
            rdata_d       = acc_rdat;
            rdata_valid_d = 1'b1;
            state_d       = ST_FIN;
         end
         ST_FIN:  state_d = (err_q == ERR_TIMEOUT) ? ST_INIT_CTR : ST_IDLE;
         default: state_d = ST_INIT_LO;
      endcase

      // Every path into FIN ends the transaction; a non-OK code marks it failed.
      if (state_d == ST_FIN && state_q != ST_FIN) begin
         done_d = 1'b1;
         if (err_d != ERR_OK) begin
            error_d      = 1'b1;
            page_valid_d = 1'b0;
         end
      end

      tmo_cnt_d = (in_poll && state_d == state_q) ?
                  (tmo_hit ? tmo_cnt_q : tmo_cnt_q + 1'b1) : '0;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= ST_INIT_LO;
         phase_q       <= PH_PG;
         err_q         <= ERR_OK;
         step_q        <= '0;
         retry_q       <= '0;
         tmo_cnt_q     <= '0;
         rw_q          <= 1'b0;
         page_valid_q  <= 1'b0;
         pend_q        <= 1'b0;
         page_q        <= '0;
         reg_q         <= '0;
         wdata_q       <= '0;
         last_page_q   <= '0;
         rdata_q       <= '0;
         rdata_valid_q <= 1'b0;
         done_q        <= 1'b0;
         error_q       <= 1'b0;
      end else begin
         state_q       <= state_d;
         phase_q       <= phase_d;
         err_q         <= err_d;
         step_q        <= step_d;
         retry_q       <= retry_d;
         tmo_cnt_q     <= tmo_cnt_d;
         rw_q          <= rw_d;
         page_valid_q  <= page_valid_d;
         pend_q        <= pend_d;
         page_q        <= page_d;
         reg_q         <= reg_d;
         wdata_q       <= wdata_d;
         last_page_q   <= last_page_d;
         rdata_q       <= rdata_d;
         rdata_valid_q <= rdata_valid_d;
         done_q        <= done_d;
         error_q       <= error_d;
      end
   end

   i2c_wb_access u_access (
      .clk         (clk),
      .reset_n     (reset_n),
      .req_i       (acc_req),
      .we_i        (acc_we),
      .adr_i       (acc_adr),
      .dat_i       (acc_dat),
      .busy_o      (acc_busy),
      .ack_pulse_o (acc_ack),
      .rdat_o      (acc_rdat),
      .wb_adr_o    (wb_adr_o),
      .wb_dat_o    (wb_dat_o),
      .wb_dat_i    (wb_dat_i),
      .wb_we_o     (wb_we_o),
      .wb_stb_o    (wb_stb_o),
      .wb_cyc_o    (wb_cyc_o),
      .wb_ack_i    (wb_ack_i)
   );

   assign ready       = (state_q == ST_IDLE);
   assign done        = done_q;
   assign error       = error_q;
   assign err_code    = err_q;
   assign rdata       = rdata_q;
   assign rdata_valid = rdata_valid_q;

endmodule

// File: tb/tb_i2c_wb_seq_ctrl.sv
// Bench for i2c_wb_seq_ctrl: behavioural I2C-core Wishbone responder plus a
// transaction-level model of the expected TXR/CR/PRER/CTR write stream.
`timescale 1ns/1ps
module tb_i2c_wb_seq_ctrl;

   localparam logic [6:0]  SADR        = 7'h10;
   localparam logic [15:0] PRESCALE    = 16'h003F;
   localparam logic [7:0]  PAGE_REG    = 8'h01;
   localparam int          MAX_RETRY   = 3;
   localparam int          TIMEOUT_CYC = 4096;

   logic        clk = 1'b0, reset_n = 1'b0, start = 1'b0, rw = 1'b0;
   logic [15:0] address = '0;
   logic [7:0]  wdata = '0;
   logic [7:0]  rdata, wb_dat_o, wb_dat_i;
   logic        rdata_valid, ready, done, error, wb_we_o, wb_stb_o, wb_cyc_o, wb_ack_i;
   logic [1:0]  err_code;
   logic [2:0]  wb_adr_o;

   i2c_wb_seq_ctrl #(
      .SADR(SADR), .PRESCALE(PRESCALE), .PAGE_REG(PAGE_REG),
      .MAX_RETRY(MAX_RETRY), .TIMEOUT_CYC(TIMEOUT_CYC)
   ) dut (
      .clk(clk), .reset_n(reset_n), .start(start), .rw(rw), .address(address),
      .wdata(wdata), .rdata(rdata), .rdata_valid(rdata_valid), .ready(ready),
      .done(done), .error(error), .err_code(err_code), .wb_adr_o(wb_adr_o),
      .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i), .wb_we_o(wb_we_o),
      .wb_stb_o(wb_stb_o), .wb_cyc_o(wb_cyc_o), .wb_ack_i(wb_ack_i)
   );

   always #5 clk = ~clk;

   int n_checks = 0, n_pass = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
   endtask

   // ---------------- I2C core responder ----------------
   bit          nack_all = 0, al_arm = 0, stuck_tip = 0, seen = 0;
   logic [7:0]  rx_byte = '0, sr_m = '0;
   logic [11:0] hold;
   int          tip_reads = 0, delay_left = 0, prot_err = 0;
   logic [10:0] wr_log[$];

   task automatic serve();
      if (wb_we_o) begin
         wr_log.push_back({wb_adr_o, wb_dat_o});
         if (wb_adr_o == 3'd4) begin
            tip_reads = $urandom_range(0, 3);
            sr_m = 8'h00;
            if (nack_all && wb_dat_o == 8'h90) sr_m[7] = 1'b1;
            if (al_arm && wb_dat_o == 8'h90) begin sr_m[5] = 1'b1; al_arm = 0; end
         end
      end else if (wb_adr_o == 3'd4) begin
         wb_dat_i = sr_m | ((stuck_tip || tip_reads > 0) ? 8'h02 : 8'h00);
         if (tip_reads > 0) tip_reads--;
      end else if (wb_adr_o == 3'd3) wb_dat_i = rx_byte;
      else wb_dat_i = 8'hEE;
   endtask

   initial begin
      wb_ack_i = 1'b0;
      wb_dat_i = 8'h00;
      forever begin
         @(posedge clk); #1;
         if (!reset_n) begin
            wb_ack_i = 1'b0;
            seen = 0;
         end else if (wb_ack_i) begin
            wb_ack_i = 1'b0;
            seen = 0;
            if (wb_cyc_o || wb_stb_o) prot_err++;
         end else if (wb_cyc_o && wb_stb_o) begin
            if (!seen) begin
               seen = 1;
               hold = {wb_we_o, wb_adr_o, wb_dat_o};
               delay_left = $urandom_range(0, 2);
            end
            if ({wb_we_o, wb_adr_o, wb_dat_o} != hold) prot_err++;
            if (delay_left > 0) delay_left--;
            else begin serve(); wb_ack_i = 1'b1; end
         end
      end
   end

   // ---------------- output monitor ----------------
   int         done_cnt = 0, rv_cnt = 0;
   logic       cap_err;
   logic [1:0] cap_code;
   logic [7:0] cap_rdata;

   initial forever begin
      @(negedge clk);
      if (done) begin done_cnt++; cap_err = error; cap_code = err_code; end
      if (rdata_valid) begin rv_cnt++; cap_rdata = rdata; end
   end

   // ---------------- transaction-level reference model ----------------
   bit          m_pv = 0;
   logic [7:0]  m_lp = '0;
   logic [10:0] exp_q[$];
   logic [1:0]  exp_code;
   bit          exp_rdv;

   task automatic add_op(input logic [7:0] tx, input logic [7:0] cr);
      exp_q.push_back({3'd3, tx});
      exp_q.push_back({3'd4, cr});
   endtask

   task automatic model_txn(input logic r, input logic [15:0] a, input logic [7:0] d,
                            input bit nk, input bit al, input bit tmo);
      exp_q.delete();
      exp_code = 2'b00;
      exp_rdv  = 0;
      if (tmo) begin
         add_op({SADR, 1'b0}, 8'h90);
         exp_q.push_back({3'd2, 8'h80});
         exp_code = 2'b10; m_pv = 0; return;
      end
      if (al) begin
         add_op({SADR, 1'b0}, 8'h90);
         exp_code = 2'b11; m_pv = 0; return;
      end
      if (nk) begin
         for (int i = 0; i <= MAX_RETRY; i++) begin
            add_op({SADR, 1'b0}, 8'h90);
            exp_q.push_back({3'd4, 8'h40});
         end
         exp_code = 2'b01; m_pv = 0; return;
      end
      if (!m_pv || a[15:8] != m_lp) begin
         add_op({SADR, 1'b0}, 8'h90);
         add_op(PAGE_REG, 8'h10);
         add_op(a[15:8], 8'h50);
         m_pv = 1; m_lp = a[15:8];
      end
      add_op({SADR, 1'b0}, 8'h90);
      add_op(a[7:0], 8'h10);
      if (r) begin
         add_op({SADR, 1'b1}, 8'h90);
         exp_q.push_back({3'd4, 8'h68});
         exp_rdv = 1;
      end else add_op(d, 8'h50);
   endtask

   task automatic wait_ready(input int limit);
      for (int n = 0; n < limit && !ready; n++) @(negedge clk);
   endtask

   task automatic compare_log(input string tag);
      logic [10:0] got;
      check({tag, ".nwr"}, wr_log.size(), exp_q.size());
      for (int i = 0; i < exp_q.size(); i++) begin
         got = (i < wr_log.size()) ? wr_log[i] : 11'h7FF;
         check($sformatf("%s.wr%0d", tag, i), got, exp_q[i]);
      end
   endtask

   task automatic check_init(input string tag);
      exp_q.delete();
      exp_q.push_back({3'd0, PRESCALE[7:0]});
      exp_q.push_back({3'd1, PRESCALE[15:8]});
      exp_q.push_back({3'd2, 8'h80});
      wait_ready(500);
      check({tag, ".ready"}, ready, 1);
      compare_log(tag);
   endtask

   task automatic run_txn(input string tag, input logic r, input logic [15:0] a,
                          input logic [7:0] d, input bit nk, input bit al,
                          input bit tmo, input logic [7:0] rxb);
      wait_ready(500);
      nack_all = nk; al_arm = al; stuck_tip = tmo; rx_byte = rxb;
      model_txn(r, a, d, nk, al, tmo);
      wr_log.delete(); done_cnt = 0; rv_cnt = 0;
      rw = r; address = a; wdata = d; start = 1'b1;
      @(negedge clk); start = 1'b0;
      repeat (2) @(negedge clk);
      rw = 1'b0; address = 16'hFFFF; wdata = 8'h00; start = 1'b1;
      @(negedge clk); start = 1'b0;
      for (int n = 0; n < 20000 && done_cnt == 0; n++) @(negedge clk);
      wait_ready(500);
      check({tag, ".ready"}, ready, 1);
      check({tag, ".done_cnt"}, done_cnt, 1);
      check({tag, ".err_at_done"}, cap_err, (exp_code != 2'b00));
      check({tag, ".code_at_done"}, cap_code, exp_code);
      check({tag, ".err_sticky"}, error, (exp_code != 2'b00));
      check({tag, ".code_sticky"}, err_code, exp_code);
      check({tag, ".rv_cnt"}, rv_cnt, exp_rdv);
      if (exp_rdv) check({tag, ".rdata"}, cap_rdata, rxb);
      compare_log(tag);
      nack_all = 0; al_arm = 0; stuck_tip = 0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: got=%0d checks expected=completion", n_checks);
      $fatal(1, "simulation time limit");
   end

   initial begin
      bit r, nk, al;
      logic [15:0] a;

      repeat (3) @(negedge clk);
      check("rst.ready", ready, 0);
      check("rst.done", done, 0);
      check("rst.error", error, 0);
      check("rst.err_code", err_code, 0);
      check("rst.rdata_valid", rdata_valid, 0);
      check("rst.cyc", wb_cyc_o, 0);
      check("rst.stb", wb_stb_o, 0);
      wr_log.delete();
      reset_n = 1'b1;
      check_init("init");

      run_txn("w_0205", 0, 16'h0205, 8'hA5, 0, 0, 0, 8'h00);
      run_txn("w_0206", 0, 16'h0206, 8'h11, 0, 0, 0, 8'h00);
      run_txn("r_0207", 1, 16'h0207, 8'h00, 0, 0, 0, 8'h3C);
      run_txn("nack",   0, 16'h0208, 8'h55, 1, 0, 0, 8'h00);
      run_txn("w_after_nack", 0, 16'h0208, 8'h55, 0, 0, 0, 8'h00);
      run_txn("arb",    1, 16'h0209, 8'h00, 0, 1, 0, 8'h77);
      run_txn("r_after_arb", 1, 16'h0209, 8'h00, 0, 0, 0, 8'hC3);
`ifdef I2C_SEQ_TIMEOUT_EN
      run_txn("tmo",    0, 16'h020A, 8'h66, 0, 0, 1, 8'h00);
      run_txn("w_after_tmo", 0, 16'h020A, 8'h66, 0, 0, 0, 8'h00);
`endif

      for (int t = 0; t < 30; t++) begin
         r  = $urandom_range(0, 1);
         a  = {6'd0, 2'($urandom_range(0, 2)), 8'($urandom)};
         nk = ($urandom_range(0, 5) == 0);
         al = !nk && ($urandom_range(0, 7) == 0);
         run_txn($sformatf("rnd%0d", t), r, a, 8'($urandom), nk, al, 0, 8'($urandom));
      end

      // Reset in the middle of a transaction must drop the strobes at once.
      wait_ready(500);
      done_cnt = 0;
      rw = 1'b0; address = 16'h0301; wdata = 8'h5A; start = 1'b1;
      @(negedge clk); start = 1'b0;
      for (int n = 0; n < 100 && !wb_cyc_o; n++) @(negedge clk);
      check("abort.cyc_before", wb_cyc_o, 1);
      #2 reset_n = 1'b0;
      #1;
      check("abort.cyc", wb_cyc_o, 0);
      check("abort.stb", wb_stb_o, 0);
      check("abort.ready", ready, 0);
      m_pv = 0;
      repeat (2) @(negedge clk);
      wr_log.delete();
      reset_n = 1'b1;
      check_init("reinit");
      check("abort.done_cnt", done_cnt, 0);
      run_txn("w_after_abort", 0, 16'h0301, 8'h5A, 0, 0, 0, 8'h00);

      check("wb_protocol_errors", prot_err, 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
